my_serial_adder: RTL and testbench
==================================

# my_serial_adder

Bit-serial N-bit adder controller that time-shares a single full-adder slice, built from two `my_half_adder` instances and an OR gate, across all operand bits. It latches two operands on a start request and feeds one bit pair per clock, LSB first, through the slice. A registered carry links consecutive bits. It returns the N-bit sum and carry-out with a one-cycle `done` pulse. It is the sequencing layer between a requester (bench or larger datapath) and the half-adder datapath.

## Interface
- `WIDTH`, default 8: operand/sum width in bits; legal range 1..32.
- `clk`  input  1  rising-edge clock; one clock domain only.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request an addition; sampled only when idle (state IDLE or DONE).
- `a`  input  WIDTH  operand A; sampled on the accepting edge only.
- `b`  input  WIDTH  operand B; sampled on the accepting edge only.
- `busy`  output  1  high while an addition is in progress (state RUN).
- `done`  output  1  one-cycle pulse; `sum`/`carry_out` valid from this cycle.
- `sum`  output  WIDTH  result bits, held until the next completion.
- `carry_out`  output  1  final carry of the addition, held with `sum`.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: `start`=1 → RUN.
  - RUN: bit counter == WIDTH-1 → DONE; otherwise stay in RUN.
  - DONE: `start`=1 → RUN; otherwise → IDLE.
- Accepting edge:
  - `a` and `b` are loaded into shift registers `sa` and `sb`.
  - Carry flop is loaded with 0 (or `cin`, see Configuration).
  - Bit counter is set to 0.
- Each RUN cycle:
  - Half adder 1 computes `sa[0]` + `sb[0]`.
  - Half adder 2 adds the HA1 sum and the carry flop.
  - Bit result = HA2 sum; new carry = HA1 carry OR HA2 carry.
  - The bit result shifts into the MSB of a working sum register, which shifts right.
  - `sa` and `sb` shift right; the carry flop updates; the counter increments.
- On the final RUN edge:
  - `sum` takes the completed working register, including the bit just computed.
  - `carry_out` takes the new carry.
- Arithmetic is unsigned modulo 2^WIDTH; `carry_out` is bit WIDTH of the true sum.
- `start` is ignored during RUN. No queueing, no error flag.
- Changing `a`/`b` after the accepting edge has no effect on the result in flight.
- `rst` mid-operation aborts the addition. No `done` is produced and outputs return to reset values.
- The datapath slice contains only the two `my_half_adder` instances and one OR gate. No behavioural `+` anywhere in the block.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `sum`=0, `carry_out`=0. Counter, carry and shift registers are cleared.
- Let E0 be the rising edge that samples `start`=1 while idle.
  - `busy` is high for cycles E0+1 .. E0+WIDTH, i.e. exactly WIDTH cycles.
  - `done`, `sum` and `carry_out` update on edge E0+WIDTH.
  - `done` is high only in cycle E0+WIDTH..E0+WIDTH+1.
- Latency is WIDTH cycles from the accepting edge to `done`.
- Back-to-back operation: `start`=1 during the DONE cycle is accepted. `busy` then reasserts in the very next cycle, giving throughput of one addition per WIDTH+1 cycles.
- `sum`/`carry_out` change only on a completion edge or reset; they are stable between completions.
- WIDTH=1: RUN lasts one cycle; `done` appears one cycle after acceptance.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `MY_SERIAL_ADDER_CARRY_IN_EN`.
- Defined:
  - Adds port `cin`, input, 1 bit, sampled on the accepting edge and loaded into the carry flop.
  - Result is `a` + `b` + `cin`.
- Undefined:
  - No `cin` port; the carry flop loads 0 on acceptance.
  - Result is `a` + `b`.
- Timing and FSM are identical in both builds.

## Test plan
All scenarios use WIDTH=8.
- After reset, start with `a`=0x00, `b`=0x00 → `done` 8 cycles later; `sum`=0x00, `carry_out`=0; `busy` high exactly 8 cycles.
- `a`=0xFF, `b`=0x01 → `sum`=0x00, `carry_out`=1.
- `a`=0xA5, `b`=0x5A → `sum`=0xFF, `carry_out`=0.
- `a`=0x80, `b`=0x80 → `sum`=0x00, `carry_out`=1.
- Add 0x12+0x34. Pulse `start` with 0xFF/0xFF mid-RUN → ignored; result 0x46, `carry_out`=0. Then start 0x0F+0x01 in the DONE cycle → accepted; `busy` next cycle; `sum`=0x10 after 8 more cycles.
- Assert `rst` 4 cycles into an addition → next cycle `busy`=0, `sum`=0x00, no `done`.
- With `MY_SERIAL_ADDER_CARRY_IN_EN`: `cin`=1, `a`=0xFF, `b`=0x00 → `sum`=0x00, `carry_out`=1.

Source files
------------

// File: rtl/my_serial_adder.sv
// my_serial_adder: bit-serial adder sharing one half-adder-pair slice, LSB first; MY_SERIAL_ADDER_CARRY_IN_EN adds a cin port.
module my_half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module my_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MY_SERIAL_ADDER_CARRY_IN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st, nx;
  logic [WIDTH-1:0] sa, sb, ws, ws_nx, cnt;
  logic cy, cn, s1, c1, s2, c2, last, accept, cin_v;
`ifdef MY_SERIAL_ADDER_CARRY_IN_EN
  assign cin_v = cin;
`else
  assign cin_v = 1'b0;
`endif
  my_half_adder u_ha1 (.x(sa[0]), .y(sb[0]), .s(s1), .c(c1));
  my_half_adder u_ha2 (.x(s1), .y(cy), .s(s2), .c(c2));
  assign cn = c1 | c2;
  // one-hot bit counter: the set bit marks the position being computed
  assign last = cnt[WIDTH-1];
  assign accept = (st != RUN) && start;
  assign ws_nx = WIDTH'({s2, ws} >> 1);
  assign busy = (st == RUN);
  assign done = (st == DONE);
  always_comb begin
    nx = IDLE;
    nx = (st == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      sa <= '0;
      sb <= '0;
      ws <= '0;
      cnt <= '0;
      cy <= 1'b0;
      sum <= '0;
      carry_out <= 1'b0;
    end else begin
      st <= nx;
      if (accept) begin
        sa <= a;
        sb <= b;
        ws <= '0;
        cnt <= WIDTH'(1);
        cy <= cin_v;
      end else if (st == RUN) begin
        sa <= sa >> 1;
        sb <= sb >> 1;
        ws <= ws_nx;
        cnt <= cnt << 1;
        cy <= cn;
        if (last) begin
          sum <= ws_nx;
          carry_out <= cn;
        end
      end
    end
  end
endmodule

// File: tb/tb_my_serial_adder.sv
// tb_my_serial_adder: directed vectors plus a cycle-level arithmetic model checked every cycle.
module tb_my_serial_adder;
  logic clk = 0, rst = 1, start = 0, cin = 0;
  logic [7:0] a = 0, b = 0, sum;
  logic busy, done, carry_out;
  int pass = 0, total = 0;
  int left = 0;
  logic [8:0] pend = 0;
  logic [7:0] es = 0;
  logic eco = 0, ebusy = 0, edone = 0;

  my_serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef MY_SERIAL_ADDER_CARRY_IN_EN
    .cin(cin),
`endif
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
  endtask

  // model: result is plain a+b(+cin), ready WIDTH edges after acceptance
  always @(posedge clk) begin
    if (rst) begin
      left = 0; es = 0; eco = 0; edone = 0;
    end else begin
      edone = 0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          {eco, es} = pend;
          edone = 1;
        end
      end else if (start) begin
`ifdef MY_SERIAL_ADDER_CARRY_IN_EN
        pend = {1'b0, a} + {1'b0, b} + {8'd0, cin};
`else
        pend = {1'b0, a} + {1'b0, b};
`endif
        left = 8;
      end
    end
    ebusy = (left > 0);
    #1;
    chk("busy", busy, ebusy);
    chk("done", done, edone);
    chk("sum", sum, es);
    chk("carry_out", carry_out, eco);
  end

  task automatic wait_done(output int nb);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      start = 0;
      if (busy) nb++;
      if (done) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic op(input logic [7:0] x, input logic [7:0] y, input logic [7:0] s, input logic c);
    int nb;
    @(negedge clk);
    a = x; b = y; start = 1;
    wait_done(nb);
    chk("lit_busy_cycles", nb, 8);
    chk("lit_sum", sum, s);
    chk("lit_co", carry_out, c);
  endtask

  initial begin
    int nb;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("lit_reset_sum", sum, 0);
    chk("lit_reset_busy", busy, 0);
    op(8'h00, 8'h00, 8'h00, 1'b0);
    op(8'hFF, 8'h01, 8'h00, 1'b1);
    op(8'hA5, 8'h5A, 8'hFF, 1'b0);
    op(8'h80, 8'h80, 8'h00, 1'b1);
    // start during RUN must be ignored
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1;
    wait_done(nb);
    chk("lit_midrun_sum", sum, 8'h46);
    chk("lit_midrun_co", carry_out, 0);
    // back-to-back: start in the DONE cycle
    a = 8'h0F; b = 8'h01; start = 1;
    @(posedge clk); #2;
    start = 0;
    chk("lit_b2b_busy", busy, 1);
    wait_done(nb);
    chk("lit_b2b_sum", sum, 8'h10);
    // reset mid-operation
    @(negedge clk);
    a = 8'h55; b = 8'h11; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(posedge clk); #2;
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_sum", sum, 0);
    chk("lit_rst_done", done, 0);
    @(negedge clk);
    rst = 0;
    nb = 0;
    repeat (10) begin
      @(posedge clk); #2;
      if (done) nb++;
    end
    chk("lit_rst_nodone", nb, 0);
`ifdef MY_SERIAL_ADDER_CARRY_IN_EN
    cin = 1;
    op(8'hFF, 8'h00, 8'h00, 1'b1);
    cin = 0;
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
